// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds the CHECK state.
package imem_loader_pkg;

  localparam int DEFAULT_DEPTH  = 64;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHECK = 3'd3,
`endif
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts program bytes into a 32-bit word, most-significant byte first,
// and flags the cycle on which the final byte of a word is accepted.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;

  // Next lane count and shifted word; a clear restarts at lane 0.
  always_comb begin
    lane_d = lane_q;
    word_d = word_q;
    if (clear_i) begin
      lane_d = '0;
    end else if (valid_i) begin
      word_d = {word_q[23:0], byte_i};
      lane_d = lane_q + 2'd1;
    end
  end

  // Lane counter and assembly register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  assign word_o       = word_q;
  assign word_ready_o = valid_i && !clear_i && (lane_q == LAST_LANE);

endmodule

// File: rtl/imem_loader.sv
// Loads a program byte stream into instruction memory, holding the CPU in
// reset until the load completes. Optional macro IMEM_LOADER_CHECKSUM_EN
// requires a trailing XOR checksum byte before the CPU is released.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = 7
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wordIdx_q, wordIdx_d;
  logic [CNT_W-1:0] lenWords_q, lenWords_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             startLoad;
  logic             packValid;
  logic             wordReady;
  logic [31:0]      packWord;
  logic [CNT_W-1:0] wordIdxNext;
  logic             lenOk;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       xor_q, xor_d;
`endif

  assign lenOk       = (len_words != '0) && (len_words <= DEPTH_C);
  assign wordIdxNext = wordIdx_q + ONE_C;
  assign packValid   = (state_q == RECV) && byte_valid;

  byte_packer u_packer (
    .clk_i        (Clk),
    .rst_ni       (Rst),
    .clear_i      (startLoad),
    .valid_i      (packValid),
    .byte_i       (byte_data),
    .word_o       (packWord),
    .word_ready_o (wordReady)
  );

  // Next-state logic plus the per-state handshake and write strobes.
  always_comb begin
    state_d    = state_q;
    wordIdx_d  = wordIdx_q;
    lenWords_d = lenWords_q;
    done_d     = done_q;
    err_d      = err_q;
    startLoad  = 1'b0;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          done_d = 1'b0;
          if (lenOk) begin
            startLoad  = 1'b1;
            state_d    = RECV;
            lenWords_d = len_words;
            wordIdx_d  = '0;
            err_d      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d      = '0;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RECV: begin
        byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (byte_valid) xor_d = xor_q ^ byte_data;
`endif
        if (wordReady) state_d = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (wordIdxNext < lenWords_q) begin
          wordIdx_d = wordIdxNext;
          state_d   = RECV;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (byte_data == xor_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, counters and status flags; reset abandons any load in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= IDLE;
      wordIdx_q  <= '0;
      lenWords_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wordIdx_q  <= wordIdx_d;
      lenWords_q <= lenWords_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign mem_addr  = mem_we ? {{(32-CNT_W-2){1'b0}}, wordIdx_q, 2'b00} : 32'd0;
  assign mem_wdata = mem_we ? packWord : 32'd0;
  assign busy      = (state_q == RECV) || (state_q == WRITE)
`ifdef IMEM_LOADER_CHECKSUM_EN
                     || (state_q == CHECK)
`endif
                     ;
  assign cpu_rst   = (state_q != DONE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, meaning the instruction-memory capacity in 32-bit words.
REQ-002 The module SHALL have parameter CNT_W, default 7, meaning the width of word counters; it holds values 0..DEPTH.
REQ-003 Port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port Rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port start, input, 1 bit: one-cycle request to begin a program load.
REQ-006 Port len_words, input, CNT_W bits: number of words to load; sampled on the accepted start.
REQ-007 Port byte_valid, input, 1 bit: byte_data is valid.
REQ-008 Port byte_data, input, 8 bits: next program byte, most-significant byte of each word first.
REQ-009 Port byte_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-010 Port mem_we, output, 1 bit: instruction-memory write strobe.
REQ-011 Port mem_addr, output, 32 bits: byte address of the written word, word-aligned and PC-compatible.
REQ-012 Port mem_wdata, output, 32 bits: assembled instruction word.
REQ-013 Port cpu_rst, output, 1 bit: active-high hold-reset for the processor datapath.
REQ-014 Port busy, output, 1 bit: a load is in progress.
REQ-015 Port done, output, 1 bit: the last load completed without error.
REQ-016 Port err, output, 1 bit: the last load was rejected or failed.

Function
REQ-017 The FSM SHALL have states IDLE, RECV, WRITE, CHECK and DONE; CHECK exists only per REQ-031.
- IDLE -> RECV on start when 1 <= len_words <= DEPTH.
- On start with len_words of 0 or greater than DEPTH: stay in IDLE and set err.
REQ-018 A byte SHALL transfer only on a cycle where byte_valid and byte_ready are both 1; byte_ready = 1 only in RECV.
REQ-019 RECV SHALL shift each accepted byte into a 32-bit assembly register: word = {word[23:0], byte_data}.
REQ-020 The fourth accepted byte SHALL move the FSM to WRITE; in the next cycle mem_we = 1 for exactly one cycle with mem_wdata = the assembled word and mem_addr = word_idx*4.
REQ-021 After WRITE, word_idx SHALL increment. The FSM returns to RECV if word_idx+1 < len_words; otherwise it goes to DONE (or CHECK when REQ-031 applies).
REQ-022 Bytes presented while byte_ready = 0 SHALL be ignored, not consumed.
REQ-023 start SHALL be ignored while busy = 1.
REQ-024 start in DONE or IDLE SHALL begin a new load and clear done and err on that edge.
REQ-025 busy = 1 in RECV, WRITE and CHECK.
REQ-026 cpu_rst = 1 in every state except DONE; in DONE it is 0, releasing the processor to fetch from address 0.
REQ-027 The counters SHALL NOT wrap: len_words is validated before load, and word_idx never exceeds len_words-1.

Reset
REQ-028 Rst low SHALL immediately force the following, regardless of clock:
- state = IDLE
- byte_ready = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0
- cpu_rst = 1, busy = 0, done = 0, err = 0
- byte counter and word_idx = 0
REQ-029 Rst asserted mid-load SHALL abandon the load with no further writes; the partially written memory is left as is.
REQ-030 Deassertion SHALL take effect on the first Clk edge after Rst rises.

Configuration
REQ-031 When IMEM_LOADER_CHECKSUM_EN is defined:
- after the last WRITE, the FSM enters CHECK with byte_ready = 1 and accepts one checksum byte.
- the checksum byte equals the XOR of all program bytes.
- on a match the FSM goes to DONE; on a mismatch it goes to IDLE with err = 1 and cpu_rst = 1.
REQ-032 When IMEM_LOADER_CHECKSUM_EN is undefined, CHECK and its XOR register SHALL be absent and the last WRITE goes directly to DONE.

Structure
REQ-033 Package imem_loader_pkg SHALL hold the state enumeration, the default DEPTH, and the bytes-per-word constant (4).
REQ-034 Byte-to-word assembly SHALL be the sub-module byte_packer: 8-bit input, 2-bit lane counter, 32-bit output, word_ready flag. Everything else stays in imem_loader.

Verification
REQ-035 Reset, then start with len_words = 1 and bytes 20,08,00,05 -> one mem_we pulse with mem_addr = 0 and mem_wdata = 0x20080005, then done = 1 and cpu_rst = 0.
REQ-036 len_words = 3 with 12 bytes and byte_valid toggled every other cycle -> writes at addresses 0, 4 and 8 in order, with no lost or duplicated bytes.
REQ-037 start with len_words = 0, and separately with DEPTH+1 -> err = 1, no mem_we, cpu_rst stays 1.
REQ-038 Rst pulsed low after 6 bytes of a len_words = 2 load -> exactly one prior write at address 0; all outputs at reset values; a new start loads correctly.
REQ-039 start pulsed again during RECV -> ignored; the load completes normally.
REQ-040 With IMEM_LOADER_CHECKSUM_EN: word 0x20080005 followed by checksum 0x2D -> done = 1; followed by checksum 0x00 -> err = 1 and cpu_rst = 1.
